// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave frame sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    READ_WAIT,
    TX,
    DONE
  } spi_state_t;

  localparam logic [3:0] FRAME_LAST = 4'd11;
  localparam logic       CMD_WRITE  = 1'b0;
  localparam logic       CMD_READ   = 1'b1;

  // A read command is an address frame until an address has been captured.
  function automatic spi_state_t decode_cmd(input logic cmd, input logic have_addr);
    case (cmd)
      CMD_WRITE: return WRITE;
      CMD_READ:  return have_addr ? READ_DATA : READ_ADD;
      default:   return WRITE;
    endcase
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-back serialiser: parallel load, MSB-first shift onto miso, done on the last bit.
module spi_tx_shifter #(
  parameter int TX_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clr,
  input  logic [TX_BITS-1:0] data,
  output logic               miso,
  output logic               done
);

  localparam int CW = $clog2(TX_BITS);

  logic [TX_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               act_q, act_d;
  logic               miso_q, miso_d;

  // The MSB goes straight to miso on load so the first bit shows one cycle after the strobe.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    miso_d = miso_q;
    if (clr) begin
      act_d  = 1'b0;
      miso_d = 1'b0;
    end else if (load) begin
      miso_d = data[TX_BITS-1];
      sh_d   = {data[TX_BITS-2:0], 1'b0};
      cnt_d  = CW'(TX_BITS - 1);
      act_d  = 1'b1;
    end else if (act_q) begin
      if (cnt_q == '0) begin
        act_d  = 1'b0;
        miso_d = 1'b0;
      end else begin
        miso_d = sh_q[TX_BITS-1];
        sh_d   = {sh_q[TX_BITS-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;
  assign done = act_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame sequencer: command decode, deserializer control, read-back on miso.
// Define SPI_CTRL_TIMEOUT_EN to bound the wait for tx_valid to TIMEOUT_CYC cycles.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int TX_BITS     = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ss_n,
  input  logic               mosi,
  input  logic [TX_BITS-1:0] tx_data,
  input  logic               tx_valid,
  output logic               dser_en,
  output logic [3:0]         edge_cnt,
  output logic [3:0]         reg_mosi,
  output logic               miso,
  output logic               busy,
  output logic               err
);

  spi_state_t state_q, state_d;
  logic       have_addr_q, have_addr_d;
  logic       dser_en_q, dser_en_d;
  logic [3:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] reg_mosi_q, reg_mosi_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       abort;
  logic       tx_load, tx_clr, tx_done;
  logic       tmo_hit;

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  assign wait_cnt_d = (state_q == READ_WAIT) ? wait_cnt_q + 1'b1 : '0;
  assign tmo_hit    = (wait_cnt_q == WCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    have_addr_d = have_addr_q;
    dser_en_d   = 1'b0;
    edge_cnt_d  = 4'd0;
    err_d       = err_q;
    abort       = 1'b0;
    tx_load     = 1'b0;
    reg_mosi_d  = ss_n ? reg_mosi_q : {reg_mosi_q[2:0], mosi};

    case (state_q)
      IDLE: begin
        if (!ss_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (ss_n) begin
          abort = 1'b1;
        end else begin
          state_d    = decode_cmd(mosi, have_addr_q);
          edge_cnt_d = 4'd1;
          dser_en_d  = 1'b1;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        // Completion is checked before ss_n so a frame ending as ss_n rises still counts.
        if (edge_cnt_q == FRAME_LAST) begin
          if (state_q == READ_DATA) begin
            have_addr_d = 1'b0;
            state_d     = READ_WAIT;
          end else begin
            if (state_q == READ_ADD) have_addr_d = 1'b1;
            state_d = DONE;
          end
        end else if (ss_n) begin
          abort = 1'b1;
        end else begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          dser_en_d  = (edge_cnt_q != FRAME_LAST - 4'd1);
        end
      end
      READ_WAIT: begin
        if (ss_n) begin
          abort = 1'b1;
        end else if (tx_valid) begin
          tx_load = 1'b1;
          state_d = TX;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      TX: begin
        if (ss_n)         abort   = 1'b1;
        else if (tx_done) state_d = DONE;
      end
      DONE: begin
        if (ss_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      dser_en_d  = 1'b0;
      edge_cnt_d = 4'd0;
    end

    tx_clr = abort;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      have_addr_q <= 1'b0;
      dser_en_q   <= 1'b0;
      edge_cnt_q  <= 4'd0;
      reg_mosi_q  <= 4'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_addr_q <= have_addr_d;
      dser_en_q   <= dser_en_d;
      edge_cnt_q  <= edge_cnt_d;
      reg_mosi_q  <= reg_mosi_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  spi_tx_shifter #(.TX_BITS(TX_BITS)) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .clr  (tx_clr),
    .data (tx_data),
    .miso (miso),
    .done (tx_done)
  );

  assign dser_en  = dser_en_q;
  assign edge_cnt = edge_cnt_q;
  assign reg_mosi = reg_mosi_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst, ss_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       dser_en, miso, busy, err;
  logic [3:0] edge_cnt, reg_mosi;

  spi_slave_ctrl #(.TX_BITS(8), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .dser_en  (dser_en),
    .edge_cnt (edge_cnt),
    .reg_mosi (reg_mosi),
    .miso     (miso),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dser;
    logic [3:0] ecnt;
    logic [3:0] rm;
    logic       miso;
    logic       busy;
    logic       err;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";

  bit         m_have = 1'b0;
  bit         m_err  = 1'b0;
  logic [3:0] m_rm   = 4'd0;

  always @(negedge clk) begin
    obs_t  e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {dser_en, edge_cnt, reg_mosi, miso, busy, err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s t=%0t got dser=%b ecnt=%0d rm=%h miso=%b busy=%b err=%b want dser=%b ecnt=%0d rm=%h miso=%b busy=%b err=%b",
                 t, $time, a.dser, a.ecnt, a.rm, a.miso, a.busy, a.err,
                 e.dser, e.ecnt, e.rm, e.miso, e.busy, e.err);
      end
    end
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  task automatic cyc(input bit ss, input bit mo, input bit txv, input logic [7:0] txd,
                     input bit e_dser, input int e_ec, input bit e_miso, input bit e_busy,
                     input bit set_err);
    obs_t e;
    ss_n = ss; mosi = mo; tx_valid = txv; tx_data = txd;
    if (rst) begin
      m_rm = 4'd0; m_err = 1'b0; m_have = 1'b0;
    end else begin
      if (!ss) m_rm = {m_rm[2:0], mo};
      if (set_err) m_err = 1'b1;
    end
    @(posedge clk); #1;
    e.dser = e_dser; e.ecnt = 4'(e_ec); e.rm = m_rm;
    e.miso = e_miso; e.busy = e_busy; e.err = m_err;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic frame(input bit cmd, input logic [9:0] bits, input int abort_at,
                       input logic [7:0] d, input int wait_n, input bit end_hi, input bit tmo);
    int kind;
    kind = (cmd == 1'b0) ? 0 : (m_have ? 2 : 1);
    cyc(1'b0, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      if (abort_at == k - 1) begin
        cyc(1'b1, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b0, 1'b1);
        return;
      end
      cyc(1'b0, (k == 1) ? cmd : bits[11-k], rb(), rbyte(), (k <= 10), k, 1'b0, 1'b1, 1'b0);
    end
    if (kind != 2) begin
      if (kind == 1) m_have = 1'b1;
      cyc(end_hi, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
      if (!end_hi) repeat (wait_n) cyc(1'b0, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
    end else begin
      m_have = 1'b0;
      cyc(1'b0, rb(), 1'b0, rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
      if (tmo) begin
        repeat (TMO - 1) cyc(1'b0, rb(), 1'b0, rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, rb(), 1'b0, rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || dut.state_q !== spi_pkg::DONE) begin
          errors++;
          $display("FAIL expired_wait t=%0t err=%b busy=%b state=%0d", $time, err, busy, dut.state_q);
        end
      end else begin
        repeat (wait_n) cyc(1'b0, rb(), 1'b0, rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, rb(), 1'b1, d, 1'b0, 0, d[7], 1'b1, 1'b0);
        for (int i = 6; i >= 0; i--) cyc(1'b0, rb(), rb(), rbyte(), 1'b0, 0, d[i], 1'b1, 1'b0);
        cyc(1'b0, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b1, 1'b0);
      end
    end
    cyc(1'b1, rb(), rb(), rbyte(), 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ab;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    cur_tag = "reset";
    do_reset();
    do_reset();
    idle(5);
    checks++;
    if ({dser_en, edge_cnt, reg_mosi, miso, busy, err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state t=%0t dser=%b ecnt=%0d rm=%h miso=%b busy=%b err=%b",
               $time, dser_en, edge_cnt, reg_mosi, miso, busy, err);
    end

    cur_tag = "write";
    frame(1'b0, 10'b10_1010_1010, -1, 8'h00, 2, 1'b0, 1'b0);
    idle(2);
    cur_tag = "read_addr";
    frame(1'b1, 10'($urandom), -1, 8'h00, 1, 1'b1, 1'b0);
    idle(1);
    cur_tag = "read_data";
    frame(1'b1, 10'($urandom), -1, 8'hA5, 3, 1'b0, 1'b0);
    idle(1);
    cur_tag = "read_noaddr";
    frame(1'b1, 10'($urandom), -1, 8'h3C, 1, 1'b0, 1'b0);
    cur_tag = "write_keeps_addr";
    frame(1'b0, 10'($urandom), -1, 8'h00, 1, 1'b1, 1'b0);
    cur_tag = "read_after_write";
    frame(1'b1, 10'($urandom), -1, 8'h5A, 0, 1'b0, 1'b0);
    cur_tag = "abort";
    frame(1'b0, 10'($urandom), 6, 8'h00, 0, 1'b0, 1'b0);
    idle(2);
`ifdef SPI_CTRL_TIMEOUT_EN
    cur_tag = "timeout";
    do_reset();
    frame(1'b1, 10'($urandom), -1, 8'h00, 0, 1'b1, 1'b0);
    frame(1'b1, 10'($urandom), -1, 8'h00, 0, 1'b0, 1'b1);
`endif

    cur_tag = "random";
    for (int n = 0; n < 60; n++) begin
      if (n == 30) begin
        cur_tag = "mid_reset";
        do_reset();
        cur_tag = "random";
      end
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
      frame(rb(), 10'($urandom), ab, rbyte(), int'($urandom_range(0, 4)), rb(), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Frame sequencer for the SPI slave front end. Tracks `ss_n`, decodes the command bit of each frame, and drives the shared deserializer through `dser_en`, `edge_cnt` and `reg_mosi`. Enforces the read-address / read-data ordering and serialises the 8-bit read-back byte onto `miso` once `tx_valid` arrives. Sits between the SPI pins (already synchronised to `clk`) and the deserializer/RAM pair.

## Interface
- `TX_BITS`, 8: width of the read-back byte shifted on `miso`.
- `TIMEOUT_CYC`, 16: maximum cycles in READ_WAIT. Used only with `SPI_CTRL_TIMEOUT_EN`.
- `clk`  in  1: single clock; all logic is sampled on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ss_n`  in  1: slave select, active low, already synchronous to `clk`.
- `mosi`  in  1: serial input, one bit per `clk` while `ss_n`=0.
- `tx_data`  in  TX_BITS: read-back byte from RAM.
- `tx_valid`  in  1: one-cycle strobe; `tx_data` is valid.
- `dser_en`  out  1: deserializer shift enable.
- `edge_cnt`  out  4: bit position within the current frame, 0..11.
- `reg_mosi`  out  4: shift register holding the last 4 `mosi` bits, newest in bit 0.
- `miso`  out  1: serial output.
- `busy`  out  1: high in every state except IDLE.
- `err`  out  1: sticky protocol-error flag, cleared only by `rst`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, TX, DONE.
- IDLE: when `ss_n`=0, go to CHK_CMD with `edge_cnt`=0.
- CHK_CMD: lasts one cycle; samples `mosi` as the command bit.
  - `mosi`=0: go to WRITE.
  - `mosi`=1 and `have_addr`=0: go to READ_ADD.
  - `mosi`=1 and `have_addr`=1: go to READ_DATA.
  - `edge_cnt` becomes 1.
- WRITE, READ_ADD, READ_DATA:
  - `dser_en`=1.
  - `edge_cnt` increments each cycle and stops at 11.
  - On the cycle `edge_cnt`==11 (frame complete), `dser_en`=0.
  - WRITE goes to DONE.
  - READ_ADD sets `have_addr` and goes to DONE.
  - READ_DATA clears `have_addr` and goes to READ_WAIT.
- READ_WAIT: on `tx_valid`, load `tx_data` into the TX shifter and go to TX.
- TX: drive `miso` MSB first, one bit per cycle, for TX_BITS cycles; then go to DONE.
- DONE: hold all outputs idle; return to IDLE when `ss_n`=1.
- `reg_mosi` shifts `{reg_mosi[2:0], mosi}` on every cycle with `ss_n`=0; it holds its value otherwise.
- `ss_n` rising in any frame state before completion (abort):
  - go to IDLE; `dser_en` and `edge_cnt` return to 0.
  - `have_addr` is unchanged.
  - `err` is set.
- Two READ_ADD frames in a row: the second is accepted and `have_addr` stays 1; this is not an error.
- A WRITE frame does not affect `have_addr`.
- `tx_valid` outside READ_WAIT is ignored.

## Timing
- Reset values: state IDLE, `have_addr`=0, `dser_en`=0, `edge_cnt`=0, `reg_mosi`=0, `miso`=0, `busy`=0, `err`=0.
- All outputs are registered.
- Frame length: 1 CHK_CMD cycle plus 10 data cycles; `edge_cnt` reaches 11 exactly 11 cycles after IDLE exits.
- The deserializer's `rx_valid` follows one cycle after `edge_cnt`==11.
- Read-back: first `miso` bit appears one cycle after the `tx_valid` cycle; the last bit appears TX_BITS cycles later.
- `ss_n`=1 and frame completion in the same cycle: completion wins, then the block goes to IDLE.
- `rst` overrides all state in the cycle it is sampled.

## Configuration
- `SPI_CTRL_TIMEOUT_EN` defined: READ_WAIT counts cycles. If `tx_valid` has not arrived after TIMEOUT_CYC cycles, set `err`, drive `miso`=0, and go to DONE.
- `SPI_CTRL_TIMEOUT_EN` undefined: READ_WAIT waits indefinitely, ending only on `tx_valid` or `ss_n` rising. No counter logic is synthesised.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_state_t`;
  - constants `FRAME_LAST = 4'd11`, `CMD_WRITE = 1'b0`, `CMD_READ = 1'b1`.
- One sub-module, `spi_tx_shifter`: parallel load, MSB-first shift, and a `done` pulse after TX_BITS shifts.
- The FSM, edge counter and `reg_mosi` stay in the top module.

## Test plan
- Reset release with `ss_n`=1 for 5 cycles -> all outputs 0, `busy`=0.
- Write frame: `ss_n`=0, `mosi` = 0 then `10_1010_1010` -> `dser_en` high for 10 cycles, `edge_cnt` steps 1..11, state returns to IDLE after `ss_n`=1, `have_addr` stays 0.
- Read-address frame, then read-data frame, then `tx_valid` with `tx_data`=8'hA5 -> `miso` sequence 1,0,1,0,0,1,0,1 starting one cycle after `tx_valid`; `have_addr` goes 1 then 0.
- Abort: `ss_n` rises at `edge_cnt`=6 in WRITE -> IDLE next cycle, `err`=1, `edge_cnt`=0.
- Read-data without a prior address: first read frame is decoded as READ_ADD -> no READ_WAIT entered, `have_addr`=1.
- With `SPI_CTRL_TIMEOUT_EN`: withhold `tx_valid` -> after 16 cycles in READ_WAIT, `err`=1 and the FSM is in DONE.
